// File: rtl/epb_opb_bridge_v2.sv
// ---------------------------------------------------------------------------
// epb_opb_bridge_v2
//   Bridges one EPB (external processor bus) access into one OPB master
//   transfer. A falling edge of epb_cs_n while idle captures the EPB address,
//   byte enables, direction and write data. The bridge then arbitrates for
//   OPB, performs a single transfer with bounded retry and timeout, and
//   reports the result back to EPB with a one-cycle epb_rdy strobe.
//
// Ports
//   opb_clk, opb_rst             clock, synchronous active-high reset
//   m_request/m_buslock          OPB bus request / lock (ARB, XFER, BACKOFF)
//   m_select, m_seqaddr          OPB select (XFER only), sequential addr (0)
//   m_rnw, m_be, m_abus, m_dbus  OPB direction, byte enables, byte address,
//                                write data
//   opb_dbus, opb_xferack, opb_errack, opb_mgrant, opb_retry, opb_timeout
//                                OPB read data and slave/arbiter responses
//   epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_data_i
//                                EPB request side (synchronous to opb_clk)
//   epb_data_o, epb_data_oe_n    EPB read data and its output enable
//   epb_rdy                      one-cycle completion strobe
//   xfer_status                  00 ok, 01 errack, 10 timeout, 11 retry
//                                exhausted
//   busy                         high whenever the bridge is not idle
// ---------------------------------------------------------------------------
module epb_opb_bridge_v2 #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 25,
    parameter int TIMEOUT   = 1000,
    parameter int MAX_RETRY = 3
) (
    input  logic                opb_clk,
    input  logic                opb_rst,
    output logic                m_request,
    output logic                m_buslock,
    output logic                m_select,
    output logic                m_seqaddr,
    output logic                m_rnw,
    output logic [DATA_W/8-1:0] m_be,
    output logic [31:0]         m_abus,
    output logic [DATA_W-1:0]   m_dbus,
    input  logic [DATA_W-1:0]   opb_dbus,
    input  logic                opb_xferack,
    input  logic                opb_errack,
    input  logic                opb_mgrant,
    input  logic                opb_retry,
    input  logic                opb_timeout,
    input  logic                epb_cs_n,
    input  logic                epb_oe_n,
    input  logic                epb_r_w_n,
    input  logic [DATA_W/8-1:0] epb_be_n,
    input  logic [ADDR_W-1:0]   epb_addr,
    input  logic [DATA_W-1:0]   epb_data_i,
    output logic [DATA_W-1:0]   epb_data_o,
    output logic                epb_data_oe_n,
    output logic                epb_rdy,
    output logic [1:0]          xfer_status,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(BE_W);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_MAX = RTY_W'(MAX_RETRY);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_WAIT_CS = 3'd5;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_RETRY = 2'b11;

    logic [2:0]        state_q,     state_d;
    logic              prev_cs_n_q, prev_cs_n_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [BE_W-1:0]   be_q,        be_d;
    logic              rnw_q,       rnw_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic [1:0]        status_q,    status_d;
    logic [RTY_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

    logic start;
    assign start = prev_cs_n_q && !epb_cs_n && (state_q == S_IDLE);

    // NOTE: always_comb opens with a default for every _d signal (hold), so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        prev_cs_n_d = epb_cs_n;
        addr_d      = addr_q;
        be_d        = be_q;
        rnw_d       = rnw_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        retry_cnt_d = retry_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = epb_addr;
                    be_d        = ~epb_be_n;
                    rnw_d       = epb_r_w_n;
                    wdata_d     = epb_data_i;
                    retry_cnt_d = '0;
                    state_d     = S_ARB;
                end
            end
            S_ARB: begin
                if (opb_mgrant) begin
                    tmo_cnt_d = '0;
                    state_d   = S_XFER;
                end
            end
            S_XFER: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (opb_xferack) begin
                    status_d = ST_OK;
                    if (rnw_q) rdata_d = opb_dbus;
                    state_d  = S_DONE;
                end else if (opb_errack) begin
                    status_d = ST_ERR;
                    rdata_d  = '0;
                    state_d  = S_DONE;
                end else if (opb_timeout || (tmo_cnt_q == TMO_LAST)) begin
                    status_d = ST_TMO;
                    rdata_d  = '0;
                    state_d  = S_DONE;
                end else if (opb_retry) begin
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        state_d     = S_BACKOFF;
                    end else begin
                        status_d = ST_RETRY;
                        rdata_d  = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BACKOFF: state_d = S_ARB;
            S_DONE:    state_d = S_WAIT_CS;
            S_WAIT_CS: if (epb_cs_n) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: the captured request registers are reset too, because they drive
    // m_abus/m_be/m_rnw directly and those must read zero out of reset.
    always_ff @(posedge opb_clk) begin
        if (opb_rst) begin
            state_q     <= S_IDLE;
            prev_cs_n_q <= 1'b1;
            addr_q      <= '0;
            be_q        <= '0;
            rnw_q       <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            status_q    <= ST_OK;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_cs_n_q <= prev_cs_n_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            rnw_q       <= rnw_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            retry_cnt_q <= retry_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    logic owning_bus;
    assign owning_bus = (state_q == S_ARB) || (state_q == S_XFER) ||
                        (state_q == S_BACKOFF);

    assign m_request = owning_bus;
    assign m_buslock = owning_bus;
    assign m_select  = (state_q == S_XFER);
    assign m_seqaddr = 1'b0;
    assign m_rnw     = rnw_q;
    assign m_be      = be_q;
    assign m_abus    = 32'(addr_q) << BYTE_SHIFT;
    assign m_dbus    = (m_select && !rnw_q) ? wdata_q : '0;

    assign epb_data_o    = rdata_q;
    assign epb_data_oe_n = !(((state_q == S_DONE) || (state_q == S_WAIT_CS)) &&
                             rnw_q && !epb_oe_n);
    assign epb_rdy       = (state_q == S_DONE);
    assign xfer_status   = status_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_epb_opb_bridge_v2.sv
// ---------------------------------------------------------------------------
// tb_epb_opb_bridge_v2
//   Directed bench for epb_opb_bridge_v2 (DATA_W=32, ADDR_W=25, TIMEOUT=8,
//   MAX_RETRY=3). Inputs change 1 ns after the rising edge; outputs are
//   sampled at the same point. A negedge monitor counts epb_rdy pulses,
//   m_select cycles and backoff cycles so each scenario can check deltas.
// ---------------------------------------------------------------------------
module tb_epb_opb_bridge_v2;

    logic        opb_clk = 1'b0;
    logic        opb_rst;
    logic        m_request, m_buslock, m_select, m_seqaddr, m_rnw;
    logic [3:0]  m_be;
    logic [31:0] m_abus, m_dbus;
    logic [31:0] opb_dbus;
    logic        opb_xferack, opb_errack, opb_mgrant, opb_retry, opb_timeout;
    logic        epb_cs_n, epb_oe_n, epb_r_w_n;
    logic [3:0]  epb_be_n;
    logic [24:0] epb_addr;
    logic [31:0] epb_data_i, epb_data_o;
    logic        epb_data_oe_n, epb_rdy, busy;
    logic [1:0]  xfer_status;

    int checks = 0;
    int errors = 0;

    epb_opb_bridge_v2 #(
        .DATA_W(32), .ADDR_W(25), .TIMEOUT(8), .MAX_RETRY(3)
    ) dut (
        .opb_clk(opb_clk), .opb_rst(opb_rst),
        .m_request(m_request), .m_buslock(m_buslock), .m_select(m_select),
        .m_seqaddr(m_seqaddr), .m_rnw(m_rnw), .m_be(m_be), .m_abus(m_abus),
        .m_dbus(m_dbus), .opb_dbus(opb_dbus), .opb_xferack(opb_xferack),
        .opb_errack(opb_errack), .opb_mgrant(opb_mgrant),
        .opb_retry(opb_retry), .opb_timeout(opb_timeout),
        .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n), .epb_r_w_n(epb_r_w_n),
        .epb_be_n(epb_be_n), .epb_addr(epb_addr), .epb_data_i(epb_data_i),
        .epb_data_o(epb_data_o), .epb_data_oe_n(epb_data_oe_n),
        .epb_rdy(epb_rdy), .xfer_status(xfer_status), .busy(busy)
    );

    always #5 opb_clk = ~opb_clk;

    // Event counters, written only here.
    int   rdy_cnt = 0;
    int   sel_cnt = 0;
    int   bo_cnt  = 0;
    int   req_only_cnt = 0;
    logic prev_sel = 1'b0;
    always @(negedge opb_clk) begin
        if (epb_rdy) rdy_cnt++;
        if (m_select) sel_cnt++;
        if (m_request && !m_select) req_only_cnt++;
        if (prev_sel && m_request && !m_select) bo_cnt++;
        prev_sel = m_select;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge opb_clk);
        #1;
    endtask

    // Drop cs_n with the request; the following edge is the start cycle.
    task automatic start_xfer(input logic [24:0] addr, input logic rnw,
                              input logic [3:0] be_n, input logic [31:0] wd);
        epb_addr   = addr;
        epb_r_w_n  = rnw;
        epb_be_n   = be_n;
        epb_data_i = wd;
        epb_cs_n   = 1'b0;
        tick();
    endtask

    // From ARB: hold grant low for 'delay' cycles, then grant; ends in XFER.
    task automatic grant(input int delay);
        for (int i = 0; i < delay; i++) tick();
        opb_mgrant = 1'b1;
        tick();
        opb_mgrant = 1'b0;
    endtask

    // From XFER: present one reply cycle; ends in DONE.
    task automatic reply(input logic xack, input logic eack, input logic tmo,
                         input logic [31:0] rd);
        opb_xferack = xack;
        opb_errack  = eack;
        opb_timeout = tmo;
        opb_dbus    = rd;
        tick();
        opb_xferack = 1'b0;
        opb_errack  = 1'b0;
        opb_timeout = 1'b0;
    endtask

    // Release cs_n; WAIT_CS -> IDLE, plus one idle cycle.
    task automatic end_cs();
        epb_cs_n = 1'b1;
        tick();
        tick();
    endtask

    int rdy0, sel0, bo0, req0, n;

    initial begin
        opb_rst = 1'b1;
        opb_dbus = '0; opb_xferack = 0; opb_errack = 0; opb_mgrant = 0;
        opb_retry = 0; opb_timeout = 0;
        epb_cs_n = 1; epb_oe_n = 1; epb_r_w_n = 1; epb_be_n = 4'hF;
        epb_addr = '0; epb_data_i = '0;
        tick(); tick();

        // Reset state
        check("rst_request", {31'b0, m_request}, 0);
        check("rst_select",  {31'b0, m_select}, 0);
        check("rst_abus",    m_abus, 0);
        check("rst_be",      {28'b0, m_be}, 0);
        check("rst_busy",    {31'b0, busy}, 0);
        check("rst_oe_n",    {31'b0, epb_data_oe_n}, 1);
        check("rst_data_o",  epb_data_o, 0);
        check("rst_status",  {30'b0, xfer_status}, 0);
        opb_rst = 1'b0;
        tick();

        // Read, addr 0x10, grant after 2 cycles, xferack 0xCAFEF00D
        rdy0 = rdy_cnt;
        start_xfer(25'h10, 1'b1, 4'h0, 32'h0);
        check("rd_busy", {31'b0, busy}, 1);
        check("rd_req",  {30'b0, m_request, m_buslock}, 2'b11);
        check("rd_sel_arb", {31'b0, m_select}, 0);
        check("rd_abus", m_abus, 32'h40);
        grant(2);
        check("rd_sel_xfer", {31'b0, m_select}, 1);
        check("rd_dbus_zero", m_dbus, 0);
        reply(1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
        epb_oe_n = 1'b0;
        #1;
        check("rd_rdy", {31'b0, epb_rdy}, 1);
        check("rd_sel_after", {31'b0, m_select}, 0);
        check("rd_data_o", epb_data_o, 32'hCAFEF00D);
        check("rd_status", {30'b0, xfer_status}, 0);
        check("rd_oe_n", {31'b0, epb_data_oe_n}, 0);
        tick();
        check("rd_rdy_once", {31'b0, epb_rdy}, 0);
        epb_oe_n = 1'b1;
        end_cs();
        check("rd_idle", {31'b0, busy}, 0);
        check("rd_rdy_cnt", rdy_cnt - rdy0, 1);

        // Write 0x12345678, be_n 0011, addr 3
        start_xfer(25'h3, 1'b0, 4'b0011, 32'h12345678);
        check("wr_be", {28'b0, m_be}, 4'b1100);
        check("wr_abus", m_abus, 32'hC);
        check("wr_rnw", {31'b0, m_rnw}, 0);
        check("wr_dbus_arb", m_dbus, 0);
        grant(0);
        check("wr_dbus_xfer", m_dbus, 32'h12345678);
        reply(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        epb_oe_n = 1'b0;
        #1;
        check("wr_status", {30'b0, xfer_status}, 0);
        check("wr_oe_n", {31'b0, epb_data_oe_n}, 1);
        check("wr_dbus_done", m_dbus, 0);
        epb_oe_n = 1'b1;
        end_cs();

        // Internal timeout: no reply, m_select exactly 8 cycles
        rdy0 = rdy_cnt; sel0 = sel_cnt;
        start_xfer(25'h20, 1'b1, 4'h0, 32'h0);
        opb_mgrant = 1'b1;
        n = 0;
        while (!epb_rdy && n < 40) begin tick(); n++; end
        opb_mgrant = 1'b0;
        check("tmo_rdy_seen", {31'b0, epb_rdy}, 1);
        check("tmo_status", {30'b0, xfer_status}, 2'b10);
        check("tmo_data_o", epb_data_o, 0);
        end_cs();
        check("tmo_sel_cycles", sel_cnt - sel0, 8);
        check("tmo_rdy_cnt", rdy_cnt - rdy0, 1);

        // Retry 4 times with MAX_RETRY=3
        rdy0 = rdy_cnt; sel0 = sel_cnt; bo0 = bo_cnt; req0 = req_only_cnt;
        start_xfer(25'h1, 1'b1, 4'h0, 32'h0);
        opb_mgrant = 1'b1;
        n = 0;
        while (!epb_rdy && n < 60) begin
            opb_retry = m_select;
            tick();
            n++;
        end
        opb_retry = 1'b0;
        opb_mgrant = 1'b0;
        check("rty_rdy_seen", {31'b0, epb_rdy}, 1);
        check("rty_status", {30'b0, xfer_status}, 2'b11);
        check("rty_data_o", epb_data_o, 0);
        end_cs();
        check("rty_sel_cycles", sel_cnt - sel0, 4);
        check("rty_backoffs", bo_cnt - bo0, 3);
        check("rty_req_nosel", req_only_cnt - req0, 7);
        check("rty_rdy_cnt", rdy_cnt - rdy0, 1);

        // xferack beats errack in the same cycle
        start_xfer(25'h2, 1'b1, 4'h0, 32'h0);
        grant(1);
        reply(1'b1, 1'b1, 1'b0, 32'hA5A55A5A);
        check("both_status", {30'b0, xfer_status}, 0);
        check("both_data_o", epb_data_o, 32'hA5A55A5A);
        end_cs();

        // errack alone, then external timeout
        start_xfer(25'h2, 1'b1, 4'h0, 32'h0);
        grant(0);
        reply(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
        check("err_status", {30'b0, xfer_status}, 2'b01);
        check("err_data_o", epb_data_o, 0);
        end_cs();
        check("err_status_hold", {30'b0, xfer_status}, 2'b01);
        start_xfer(25'h2, 1'b1, 4'h0, 32'h0);
        grant(0);
        reply(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        check("otmo_status", {30'b0, xfer_status}, 2'b10);
        end_cs();

        // cs_n re-fall while busy is ignored; cs_n rising before DONE
        start_xfer(25'h5, 1'b1, 4'h0, 32'h0);
        epb_cs_n = 1'b1;
        tick();
        epb_cs_n = 1'b0;
        epb_addr = 25'h7;
        tick();
        check("refall_abus", m_abus, 32'h14);
        check("refall_busy", {31'b0, busy}, 1);
        grant(0);
        epb_cs_n = 1'b1;
        reply(1'b1, 1'b0, 1'b0, 32'h00001111);
        check("early_cs_rdy", {31'b0, epb_rdy}, 1);
        tick();
        tick();
        check("early_cs_idle", {31'b0, busy}, 0);
        tick();

        // cs_n held low after DONE keeps WAIT_CS
        start_xfer(25'h6, 1'b1, 4'h0, 32'h0);
        grant(0);
        reply(1'b1, 1'b0, 1'b0, 32'h00002222);
        tick(); tick(); tick();
        check("hold_busy", {31'b0, busy}, 1);
        check("hold_rdy", {31'b0, epb_rdy}, 0);
        end_cs();
        check("hold_idle", {31'b0, busy}, 0);

        // Reset in XFER abandons the transfer
        rdy0 = rdy_cnt;
        start_xfer(25'h8, 1'b1, 4'h0, 32'h0);
        grant(0);
        check("rstx_sel_before", {31'b0, m_select}, 1);
        opb_rst  = 1'b1;
        epb_cs_n = 1'b1;
        tick();
        check("rstx_sel", {31'b0, m_select}, 0);
        check("rstx_busy", {31'b0, busy}, 0);
        check("rstx_abus", m_abus, 0);
        opb_rst = 1'b0;
        tick(); tick(); tick();
        check("rstx_no_rdy", rdy_cnt - rdy0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
